exe_mem_skid_reg: RTL

- Elastic pipeline register on the consuming side of the EXE stage register; it feeds the MEM stage.
- Accepts EXE-stage packets (instruction word plus PC) under a valid/ready handshake and buffers up to two packets, so that a MEM-side stall never drops an instruction.
- Upstream ready is fully registered, so stalls do not create a combinational ready path back into EXE.
- Supports a pipeline flush (branch taken) and counts MEM back-pressure cycles for performance debugging.

---
 rtl/exe_mem_skid_reg_pkg.sv | 16 +
 rtl/sat_counter.sv | 20 ++
 rtl/exe_mem_skid_reg.sv | 95 +++++++++
 3 files changed

// File: rtl/exe_mem_skid_reg_pkg.sv
// Shared pipeline definitions reused by the IF/ID/EXE/MEM stage registers.
package exe_mem_skid_reg_pkg;

    localparam int unsigned INSTR_W_DEF = 32;
    localparam int unsigned PC_W_DEF    = 32;
    localparam int unsigned CNT_W_DEF   = 16;

    // Bubble inserted into the pipe when a stage is flushed.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instruction;
        logic [PC_W_DEF-1:0]    pc;
    } packet_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for per-stage performance events.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Count enabled cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM elastic register: main slot plus skid slot, registered upstream ready.
module exe_mem_skid_reg
    import exe_mem_skid_reg_pkg::*;
#(
    parameter int unsigned INSTR_W = INSTR_W_DEF,
    parameter int unsigned PC_W    = PC_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instruction,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instruction,
    output logic [PC_W-1:0]    out_pc,
    output logic [CNT_W-1:0]   stall_count
);

    logic               main_valid;
    logic [INSTR_W-1:0] main_instr;
    logic [PC_W-1:0]    main_pc;
    logic               skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;

    logic in_xfer;
    logic out_xfer;

    // Ready comes straight from the skid flop so MEM stalls never reach EXE combinationally.
    assign in_ready        = ~skid_valid;
    assign out_valid       = main_valid;
    assign out_instruction = main_instr;
    assign out_pc          = main_pc;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = main_valid & out_ready;

    // Slot update: flush first, then refill/drain of main, spill into skid on stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid <= 1'b0;
            main_instr <= '0;
            main_pc    <= '0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_instr <= INSTR_W'(NOP_INSTR);
            main_pc    <= '0;
        end else if (!main_valid) begin
            if (in_xfer) begin
                main_valid <= 1'b1;
                main_instr <= in_instruction;
                main_pc    <= in_pc;
            end
        end else if (out_xfer) begin
            if (skid_valid) begin
                // in_ready is low here, so no input can arrive alongside.
                main_instr <= skid_instr;
                main_pc    <= skid_pc;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                main_instr <= in_instruction;
                main_pc    <= in_pc;
            end else begin
                // Data fields keep their last value; only the valid drops.
                main_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid <= 1'b1;
            skid_instr <= in_instruction;
            skid_pc    <= in_pc;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (main_valid & ~out_ready),
        .count (stall_count)
    );

    // The skid slot only ever fills behind an occupied main slot.
    assert property (@(posedge clk) disable iff (!rst) !(skid_valid && !main_valid))
        else $error("skid slot valid while main slot empty");

endmodule
